block_mode_sequencer: RTL and testbench
=======================================

// Module: block_mode_sequencer
// PURPOSE
// Owns the 3-bit Block select that drives the colour-pattern block (Xpos/Ypos -> RGB).
// Round-robin arbitrates Block-change requests from N_REQ sources (keys, touch, host).
// Applies a change only on frame_start, so a frame is never torn mid-scan.
// Optional auto mode steps through patterns 0..4 after a dwell of DWELL_FRAMES frames.
// PARAMETERS
// N_REQ         4   number of requesters (>=2)
// DWELL_FRAMES  60  frames per pattern in auto mode (>=1)
// PORTS
// clk          in   1        pixel clock
// reset        in   1        asynchronous, active-high
// frame_start  in   1        one-cycle pulse at start of vertical blank
// req          in   N_REQ    req[i] high = requester i wants a change; held until gnt[i]
// req_code     in   3*N_REQ  requested code, slice i = req_code[3*i+2:3*i]
// auto_en      in   1        1 = auto-advance enabled
// gnt          out  N_REQ    one-hot, one-cycle grant pulse
// Block        out  3        pattern code to the colour block (0 = bars, 1..4 = solids)
// block_upd    out  1        one-cycle pulse on the cycle Block takes a new value
// busy         out  1        1 while a granted code is waiting for frame_start
// BEHAVIOUR
// - Reset values (async): Block=0, gnt=0, block_upd=0, busy=0.
// - Reset internals: state=IDLE, rr_ptr=0, pending=0, dwell_cnt=0.
// - Reset mid-PENDING discards the pending code.
// - All outputs are registered.
// - Sanitise rule: any code >4 maps to 0 (applies to requested codes and the auto step).
// - FSM IDLE:
//   - Grant: if |req, winner = first asserted index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - On that edge: gnt[winner]<=1 for one cycle, pending<=sanitised req_code slice.
//   - Also on that edge: rr_ptr<=(winner+1) mod N_REQ, dwell_cnt<=0, busy<=1, state->PENDING.
//   - Grant latency is 1 cycle after req is sampled.
//   - Auto advance: else if frame_start and auto_en:
//     - if dwell_cnt==DWELL_FRAMES-1: Block<=(Block==4)?0:Block+1, block_upd<=1, dwell_cnt<=0;
//     - otherwise dwell_cnt<=dwell_cnt+1.
// - FSM PENDING: no grants issued; requesters keep req asserted.
//   - On frame_start: Block<=pending, block_upd<=1 (pulses even if the value is unchanged),
//     dwell_cnt<=0, busy<=0, state->IDLE.
//   - The new Block value is visible on the edge where frame_start is sampled.
// - Simultaneous req+frame_start in IDLE: grant wins, Block unchanged, dwell_cnt<=0.
//   The granted code applies at the next frame_start.
// - frame_start in PENDING with auto_en=1: only the pending apply happens; no auto step.
// - auto_en=0: dwell_cnt held at 0.
// - auto_en rising: the count starts from 0.
// - dwell_cnt width: $clog2(DWELL_FRAMES+1); it never exceeds DWELL_FRAMES-1.
// - frame_start while IDLE, auto_en=0, no req: no effect.
// - gnt is never asserted in two consecutive cycles (the PENDING phase always intervenes).
// TESTING
// 1 Reset: assert reset mid-run -> Block=0, gnt=0, busy=0, block_upd=0 immediately;
//   after release, a frame_start with no req and auto_en=0 leaves Block=0.
// 2 Single request: req[2]=1, code=3 -> gnt=4'b0100 one cycle later, busy=1, Block stays 0;
//   next frame_start -> Block=3 and block_upd=1 on that edge, busy=0.
// 3 Round robin: req=4'b1011 held, each dropped on its grant -> grants 0,1,3 in order,
//   one per frame; Block follows each requester's code; rr_ptr ends at 0.
// 4 Auto mode, DWELL_FRAMES=3, auto_en=1: 3 frame_starts -> Block 0->1;
//   12 more -> 1->2->3->4->0 wrap, block_upd pulse at each change.
// 5 Sanitise: req[0] code=7 -> after frame_start Block=0, block_upd=1.
// 6 Collision: auto mode at dwell_cnt=2 (DWELL=3), req[1] code=2 plus frame_start same cycle
//   -> gnt[1], no auto step; next frame_start -> Block=2; dwell restarts from 0.
//   Also: reset during PENDING -> pending dropped, no later update.

Source files
------------

// File: rtl/block_mode_sequencer.sv
// Purpose: owns the 3-bit Block pattern select; round-robin arbitrates change requests
//          and applies them (or an auto-advance step) only on frame_start.
// Latency: grant one cycle after req is sampled; Block updates on the frame_start edge.
// Backpressure: while a granted code waits for frame_start (busy=1) no further grants
//          are issued; requesters hold req until their gnt pulse.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high
//   frame_start  one-cycle pulse at start of vertical blank
//   req          per-requester change request, held until the matching gnt
//   req_code     requested codes, slice i = req_code[3*i+2:3*i]
//   auto_en      enables auto-advance through patterns 0..4
//   gnt          one-hot, one-cycle grant pulse
//   Block        pattern code to the colour block (0 = bars, 1..4 = solids)
//   block_upd    one-cycle pulse on the cycle Block takes a new value
//   busy         high while a granted code waits for frame_start
module block_mode_sequencer #(
  parameter int N_REQ        = 4,
  parameter int DWELL_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_code,
  input  logic               auto_en,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         Block,
  output logic               block_upd,
  output logic               busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int DW    = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic [2:0]       pending, pending_nxt;
  logic [2:0]       block_nxt;
  logic [DW-1:0]    dwell_cnt, dwell_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             upd_nxt;
  logic             busy_nxt;

  logic             found;
  logic [PTR_W-1:0] winner;

  // Codes above 4 have no pattern behind them; fall back to colour bars.
  function automatic logic [2:0] sanitise(input logic [2:0] code);
    return (code > 3'd4) ? 3'd0 : code;
  endfunction

  // Round-robin pick: scan from rr_ptr upwards (mod N_REQ). Iterating the offset
  // downwards lets the closest asserted requester overwrite the farther ones,
  // so no early exit is needed.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    pending_nxt = pending;
    block_nxt   = Block;
    // With auto mode off the dwell count is parked at zero, so re-enabling
    // always starts a fresh dwell period.
    dwell_nxt   = auto_en ? dwell_cnt : '0;
    gnt_nxt     = '0;
    upd_nxt     = 1'b0;
    busy_nxt    = busy;

    case (state)
      IDLE: begin
        if (found) begin
          // A grant takes priority over an auto step on a coincident frame_start.
          gnt_nxt[winner] = 1'b1;
          pending_nxt     = sanitise(req_code[3*int'(winner) +: 3]);
          rr_nxt          = PTR_W'((int'(winner) + 1) % N_REQ);
          dwell_nxt       = '0;
          busy_nxt        = 1'b1;
          state_nxt       = PENDING;
        end else if (frame_start && auto_en) begin
          if (dwell_cnt == DWELL_LAST) begin
            block_nxt = (Block == 3'd4) ? 3'd0 : sanitise(Block + 3'd1);
            upd_nxt   = 1'b1;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt + DW'(1);
          end
        end
      end

      PENDING: begin
        // Only the pending apply happens here; auto stepping is suppressed.
        if (frame_start) begin
          block_nxt = pending;
          upd_nxt   = 1'b1;
          dwell_nxt = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      pending   <= 3'd0;
      dwell_cnt <= '0;
      gnt       <= '0;
      Block     <= 3'd0;
      block_upd <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      pending   <= pending_nxt;
      dwell_cnt <= dwell_nxt;
      gnt       <= gnt_nxt;
      Block     <= block_nxt;
      block_upd <= upd_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_block_mode_sequencer.sv
// Purpose: self-checking bench for block_mode_sequencer (N_REQ=4, DWELL_FRAMES=3).
// Latency: expected grant/update events are tagged with the clock edge they are due on.
// Backpressure: requesters hold req until granted, then drop it on the following cycle.
module tb_block_mode_sequencer;

  localparam int N  = 4;
  localparam int DW = 3;

  logic           clk;
  logic           reset;
  logic           frame_start;
  logic [N-1:0]   req;
  logic [3*N-1:0] req_code;
  logic           auto_en;
  logic [N-1:0]   gnt;
  logic [2:0]     Block;
  logic           block_upd;
  logic           busy;

  block_mode_sequencer #(
    .N_REQ       (N),
    .DWELL_FRAMES(DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .req        (req),
    .req_code   (req_code),
    .auto_en    (auto_en),
    .gnt        (gnt),
    .Block      (Block),
    .block_upd  (block_upd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    int edge_no;
  } ev_t;

  ev_t gq[$];   // expected grants: requester index
  ev_t uq[$];   // expected Block updates: new value

  int edges       = 0;
  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 0;

  // Requesters
  bit r_act[N];
  int r_code[N];
  int drop_idx = -1;

  // Reference model: a change is either waiting or not; frames counted since the last change.
  bit m_waiting;
  int m_pend;
  int m_next_first;
  int m_frames;
  int m_block;

  int t3_order[3];
  int t3_code[3];

  always @(posedge clk) edges++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edges);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i]             = r_act[i];
      req_code[3*i +: 3] = 3'(r_code[i]);
    end
  endtask

  // Predicts what the DUT does on the coming edge from the inputs just applied.
  task automatic model_step();
    int e = edges + 1;
    int w = -1;
    if (!m_waiting) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && r_act[(m_next_first + k) % N]) w = (m_next_first + k) % N;
      if (w >= 0) begin
        gq.push_back('{w, e});
        m_pend       = (r_code[w] > 4) ? 0 : r_code[w];
        m_next_first = (w + 1) % N;
        m_frames     = 0;
        m_waiting    = 1;
        drop_idx     = w;
      end else if (frame_start && auto_en) begin
        m_frames++;
        if (m_frames == DW) begin
          m_block  = (m_block + 1) % 5;
          m_frames = 0;
          uq.push_back('{m_block, e});
        end
      end else if (!auto_en) begin
        m_frames = 0;
      end
    end else if (frame_start) begin
      m_block   = m_pend;
      m_frames  = 0;
      m_waiting = 0;
      uq.push_back('{m_block, e});
    end else if (!auto_en) begin
      m_frames = 0;
    end
  endtask

  task automatic step(input bit fs, input bit ae);
    @(negedge clk);
    if (drop_idx >= 0) begin
      r_act[drop_idx] = 0;
      drop_idx = -1;
    end
    frame_start = fs;
    auto_en     = ae;
    drive_req();
    model_step();
  endtask

  task automatic after();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    frame_start = 1'b0;
    for (int i = 0; i < N; i++) r_act[i] = 0;
    drive_req();
    drop_idx = -1;
    gq.delete();
    uq.delete();
    m_waiting    = 0;
    m_pend       = 0;
    m_next_first = 0;
    m_frames     = 0;
    m_block      = 0;
    #1;
    check("rst_block", Block, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_upd", block_upd, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops due events whenever the DUT should present them and compares.
  always begin : monitor
    logic [N-1:0] exp_g;
    logic         exp_u;
    @(posedge clk);
    #1;
    if (mon_en) begin
      exp_g = '0;
      exp_u = 1'b0;
      if (gq.size() > 0 && gq[0].edge_no == edges) begin
        exp_g[gq[0].val] = 1'b1;
        void'(gq.pop_front());
      end
      check("gnt", gnt, exp_g);
      if (uq.size() > 0 && uq[0].edge_no == edges) begin
        exp_u = 1'b1;
        check("upd_value", Block, uq[0].val);
        void'(uq.pop_front());
      end
      check("block_upd", block_upd, exp_u);
      check("block", Block, m_block);
      check("busy", busy, m_waiting);
    end
  end

  initial begin
    bit ae;
    int rate;
    reset       = 1'b1;
    frame_start = 1'b0;
    req         = '0;
    req_code    = '0;
    auto_en     = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_act[i]  = 0;
      r_code[i] = 0;
    end
    t3_order = '{0, 1, 3};
    t3_code  = '{1, 2, 4};

    do_reset();
    mon_en = 1;

    // Frame start with nothing to do leaves Block alone
    step(1, 0); after();
    check("t1_block", Block, 0);
    check("t1_upd", block_upd, 0);

    // Single request
    r_act[2] = 1; r_code[2] = 3;
    step(0, 0); after();
    check("t2_gnt", gnt, 4'b0100);
    check("t2_busy", busy, 1);
    check("t2_block_held", Block, 0);
    step(0, 0); after();
    check("t2_gnt_once", gnt, 0);
    step(1, 0); after();
    check("t2_block", Block, 3);
    check("t2_upd", block_upd, 1);
    check("t2_busy_clr", busy, 0);

    // Round robin from pointer 0
    do_reset();
    for (int j = 0; j < 3; j++) begin
      r_act[t3_order[j]]  = 1;
      r_code[t3_order[j]] = t3_code[j];
    end
    for (int j = 0; j < 3; j++) begin
      step(0, 0); after();
      check("t3_gnt", gnt, 1 << t3_order[j]);
      step(0, 0);
      step(1, 0); after();
      check("t3_block", Block, t3_code[j]);
    end
    r_act[0] = 1; r_code[0] = 2;
    r_act[1] = 1; r_code[1] = 1;
    step(0, 0); after();
    check("t3_ptr_wrap", gnt, 4'b0001);
    step(0, 0);
    step(1, 0);

    // Auto mode: change every 3 frames, wrap after 4
    do_reset();
    for (int n = 1; n <= 15; n++) begin
      step(1, 1); after();
      if (n % 3 == 0) begin
        check("t4_block", Block, (n / 3) % 5);
        check("t4_upd", block_upd, 1);
      end else begin
        check("t4_no_upd", block_upd, 0);
      end
      step(0, 1);
    end

    // Sanitise an out-of-range code
    do_reset();
    r_act[3] = 1; r_code[3] = 2;
    step(0, 0); step(1, 0); step(0, 0);
    r_act[0] = 1; r_code[0] = 7;
    step(0, 0); step(1, 0); after();
    check("t5_block", Block, 0);
    check("t5_upd", block_upd, 1);

    // Collision of grant and auto step
    do_reset();
    step(1, 1); step(0, 1); step(1, 1); step(0, 1);
    r_act[1] = 1; r_code[1] = 2;
    step(1, 1); after();
    check("t6_gnt", gnt, 4'b0010);
    check("t6_no_step", Block, 0);
    check("t6_no_upd", block_upd, 0);
    step(0, 1);
    step(1, 1); after();
    check("t6_apply", Block, 2);
    step(0, 1); step(1, 1); step(0, 1); step(1, 1); after();
    check("t6_dwell_hold", Block, 2);
    step(0, 1); step(1, 1); after();
    check("t6_dwell_restart", Block, 3);
    step(0, 1);

    // Reset while a code is pending
    r_act[0] = 1; r_code[0] = 4;
    step(0, 1); after();
    check("t6_gnt_pre_rst", gnt, 4'b0001);
    do_reset();
    for (int n = 0; n < 3; n++) begin
      step(1, 0); after();
      check("t6_dropped", Block, 0);
      check("t6_dropped_upd", block_upd, 0);
      step(0, 0);
    end

    // Randomised traffic
    ae = 0;
    for (int c = 0; c < 4000; c++) begin
      rate = ((c / 500) % 2 == 1) ? 60 : 8;
      for (int i = 0; i < N; i++) begin
        if (!r_act[i] && $urandom_range(0, rate - 1) == 0) begin
          r_act[i]  = 1;
          r_code[i] = $urandom_range(0, 7);
        end
      end
      if ($urandom_range(0, 99) == 0) ae = !ae;
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 4) == 0, ae);
    end

    for (int i = 0; i < N; i++) r_act[i] = 0;
    step(0, 0); step(0, 0); step(0, 0); after();
    check("left_gnt", gq.size(), 0);
    check("left_upd", uq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
